keccak_absorb_sipo: RTL and testbench

Parametrised serial-in/parallel-out absorb buffer for the Keccak sponge: accepts message words over a valid/ready stream, assembles them into a RATE_W-bit rate block, and inserts the FIPS-202 pad10*1 padding with a configurable domain suffix. It sits between the message input port and the Keccak-f permutation core. It presents each completed block over a valid/ready handshake and flags the final, padded block. It replaces the fixed 1344-bit, unpadded, load-enable loader with one usable for SHA3-224/256/384/512 and SHAKE128/256.

---
 rtl/keccak_absorb_sipo.sv | 146 ++++++++++++++
 tb/tb_keccak_absorb_sipo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_sipo.sv
// Serial-in/parallel-out Keccak absorb buffer: packs message words into a rate
// block, applies pad10*1 with a domain suffix, and hands blocks to the permutation.
module keccak_absorb_sipo #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RATE_W  = 1344,
  parameter logic [7:0]  DSUFFIX = 8'h1F,
  localparam int unsigned BPW     = DATA_W / 8,
  localparam int unsigned N       = RATE_W / DATA_W,
  localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned BYTES_W = $clog2(BPW + 1)
) (
  input  logic               clk,
  input  logic               hash_init_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [BYTES_W-1:0] in_bytes,
  output logic [RATE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  typedef enum logic [1:0] {FILL, PAD, HOLD} state_e;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sfx_q, sfx_d;
  logic              valid_d, last_d;
  logic              wr_en, clr;
  logic [DATA_W-1:0] wr_word;
  logic              at_end;

  assign in_ready = (state_q == FILL);
  assign at_end   = (cnt_q == LAST_SLOT);

  // Next-state, slot write data and block flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sfx_d   = sfx_q;
    valid_d = out_valid;
    last_d  = out_last;
    wr_en   = 1'b0;
    clr     = 1'b0;
    wr_word = '0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_word = in_data;
          if (!in_last) begin
            if (at_end) begin
              state_d = HOLD;
              valid_d = 1'b1;
              last_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (in_bytes < BYTES_W'(BPW)) begin
            for (int b = 0; b < int'(BPW); b++) begin
              if (BYTES_W'(b) == in_bytes)
                wr_word[8*b +: 8] = DSUFFIX;
              else if (BYTES_W'(b) > in_bytes)
                wr_word[8*b +: 8] = 8'h00;
            end
            if (at_end) begin
              wr_word[DATA_W-1 -: 8] = wr_word[DATA_W-1 -: 8] | 8'h80;
              state_d = HOLD;
              valid_d = 1'b1;
              last_d  = 1'b1;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = PAD;
              sfx_d   = 1'b0;
            end
          end else begin
            // Full final word: suffix goes into the next slot, possibly next block
            sfx_d = 1'b1;
            if (at_end) begin
              state_d = HOLD;
              valid_d = 1'b1;
              last_d  = 1'b0;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        wr_en = 1'b1;
        if (sfx_q) begin
          wr_word[7:0] = DSUFFIX;
          sfx_d        = 1'b0;
        end
        if (at_end) begin
          wr_word[DATA_W-1 -: 8] = wr_word[DATA_W-1 -: 8] | 8'h80;
          state_d = HOLD;
          valid_d = 1'b1;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = sfx_q ? PAD : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge hash_init_n) begin
    if (!hash_init_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      sfx_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sfx_q     <= sfx_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      if (clr) begin
        out_data <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < int'(N); i++) begin
          if (cnt_q == CNT_W'(i))
            out_data[i*DATA_W +: DATA_W] <= wr_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_keccak_absorb_sipo.sv
// Randomised bench for keccak_absorb_sipo against a byte-level pad10*1 model.
module tb_keccak_absorb_sipo;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RATE_W = 1344;
  localparam int unsigned N      = RATE_W / DATA_W;
  localparam int unsigned BPW    = DATA_W / 8;
  localparam int unsigned RB     = RATE_W / 8;
  localparam logic [7:0]  SFX    = 8'h1F;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              hash_init_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_bytes;
  logic [RATE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  logic rdy_force, rdy_rand, rnd_bit;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [RATE_W-1:0] exp_q[$];
  logic              exp_last_q[$];

  assign out_ready = rdy_force | (rdy_rand & rnd_bit);

  keccak_absorb_sipo #(.DATA_W(DATA_W), .RATE_W(RATE_W), .DSUFFIX(SFX)) dut (
    .clk(clk), .hash_init_n(hash_init_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference: append suffix byte, zero-fill to the rate, set the top bit of the last byte
  task automatic model(input bq_t m);
    bq_t q;
    logic [RATE_W-1:0] blk;
    int nb;
    q = m;
    q.push_back(SFX);
    while ((q.size() % RB) != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    nb = q.size() / RB;
    for (int k = 0; k < nb; k++) begin
      blk = '0;
      for (int j = 0; j < int'(RB); j++) blk[8*j +: 8] = q[k*RB + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(k == nb - 1);
    end
  endtask

  // Block checker: compares consumed blocks and watches HOLD stability
  logic [RATE_W-1:0] prev_data;
  logic              prev_hold = 1'b0;
  always @(negedge clk) begin
    logic [RATE_W-1:0] b;
    logic l;
    if (!hash_init_n) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid && prev_hold) chk("hold_stable", 64'(out_data != prev_data), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_block", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          l = exp_last_q.pop_front();
          for (int i = 0; i < int'(N); i++)
            chk($sformatf("blk_word%0d", i), out_data[i*DATA_W +: DATA_W], b[i*DATA_W +: DATA_W]);
          chk("blk_last", 64'(out_last), 64'(l));
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = out_valid;
      end
      prev_data = out_data;
    end
  end

  task automatic drive_word(input logic [DATA_W-1:0] d, input logic last,
                            input logic [3:0] nb, input bit gaps);
    bit acc;
    int t;
    while (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("in_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input int len, input bit gaps, input bit ones, input int abort_at);
    bq_t m;
    int nw;
    logic [DATA_W-1:0] d;
    logic last;
    logic [3:0] nb;
    for (int i = 0; i < len; i++) m.push_back(ones ? 8'hFF : 8'($urandom));
    if (abort_at == 0) model(m);
    nw = (len == 0) ? 1 : (len + int'(BPW) - 1) / int'(BPW);
    for (int w = 0; w < nw; w++) begin
      if (abort_at != 0 && w == abort_at) break;
      d = {$urandom, $urandom};
      for (int b = 0; b < int'(BPW); b++)
        if (w*int'(BPW) + b < len) d[8*b +: 8] = m[w*BPW + b];
      last = (w == nw - 1);
      nb = last ? 4'(len - w*int'(BPW)) : 4'($urandom_range(0, 8));
      drive_word(d, last, nb, gaps);
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 3000) begin @(posedge clk); #1; t++; end
    if (!out_valid) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume_one();
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    rdy_force = 1'b1;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); #1; t++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    hash_init_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
    rdy_force = 1'b0; rdy_rand = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(|out_data), 64'd0);
    @(posedge clk); #1;
    hash_init_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Empty message and its fill latency
    send_msg(0, 0, 0, 0);
    edges = 0;
    while (!out_valid && edges < 100) begin @(posedge clk); #1; edges++; end
    chk("empty_latency", 64'(edges), 64'd20);
    chk("empty_w0", out_data[63:0], 64'h1F);
    chk("empty_w20", out_data[20*64 +: 64], 64'h8000_0000_0000_0000);
    chk("empty_last", 64'(out_last), 64'd1);
    consume_one();
    chk("empty_consumed", 64'(out_valid), 64'd0);

    // Partial word masking
    send_msg(3, 0, 1, 0);
    wait_valid();
    chk("mask_w0", out_data[63:0], 64'h0000_0000_1FFF_FFFF);
    consume_one();

    // Exact rate fill, then combined suffix/end byte
    send_msg(168, 0, 0, 0);
    drain();
    rdy_force = 1'b0;
    send_msg(167, 0, 0, 0);
    wait_valid();
    chk("comb_byte", 64'(out_data[RATE_W-1 -: 8]), 64'h9F);
    chk("comb_last", 64'(out_last), 64'd1);
    consume_one();
    repeat (25) @(posedge clk);
    #1;
    chk("comb_no_extra", 64'(out_valid), 64'd0);

    // Backpressure with a pending source word
    send_msg(160, 0, 0, 0);
    wait_valid();
    in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    consume_one();
    in_valid = 1'b0;
    chk("bp_resume", 64'(in_ready), 64'd1);
    rdy_force = 1'b1;
    send_msg(50, 0, 0, 0);
    drain();

    // Asynchronous reset mid-fill
    rdy_force = 1'b0;
    send_msg(100, 0, 0, 7);
    #2 hash_init_n = 1'b0;
    #1;
    chk("mid_rst_data", 64'(|out_data), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    hash_init_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    send_msg(30, 0, 0, 0);
    drain();

    // Random lengths, source gaps and sink stalls
    rdy_force = 1'b0;
    rdy_rand  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int len;
      case ($urandom_range(0, 3))
        0:       len = int'(RB) * $urandom_range(1, 2) - $urandom_range(0, 1);
        1:       len = int'(BPW) * $urandom_range(0, 40);
        default: len = $urandom_range(0, 400);
      endcase
      send_msg(len, 1, 0, 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
